// File: rtl/icsp_loader.sv
// icsp_loader: serial in-circuit programming slave for a 512 x 12 program ROM.
//
// A host clocks 6-bit commands and 16-bit data frames (LSB first) over
// icsp_clk / icsp_dat_in. Both pins are asynchronous and pass through 2-flop
// synchronizers. Inbound bits are taken on the synchronized falling edge.
// Read Data bits are launched on the synchronized rising edge.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   prog_mode         programming-mode entry; low aborts to IDLE on next clk
//   icsp_clk          host serial clock (async)
//   icsp_dat_in       host serial data (async)
//   icsp_dat_out      serial data to host during Read Data
//   icsp_dat_oe       high while icsp_dat_out is driven
//   rom_adrs          program memory address (address counter, or erase index)
//   rom_wdata         program memory write word (data latch, or 0xFFF on erase)
//   rom_we            write strobe: a write occurs on every clk edge where it is high
//   rom_rdata         program memory read word, valid one clk after rom_adrs
//   busy              high during programming or bulk erase
//   cpu_hold          registered prog_mode, holds the core in reset
//   dbg_state         current FSM state encoding
module icsp_loader #(
  parameter logic [15:0] PROG_CYCLES = 16'd1000,
  parameter int          ROM_DEPTH   = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_mode,
  input  logic        icsp_clk,
  input  logic        icsp_dat_in,
  output logic        icsp_dat_out,
  output logic        icsp_dat_oe,
  output logic [8:0]  rom_adrs,
  output logic [11:0] rom_wdata,
  output logic        rom_we,
  input  logic [11:0] rom_rdata,
  output logic        busy,
  output logic        cpu_hold,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    LOAD     = 3'd2,
    RD_FETCH = 3'd3,
    RD_SHIFT = 3'd4,
    PROG     = 3'd5,
    ERASE    = 3'd6
  } state_t;

  localparam logic [15:0] PROG_LAST  = PROG_CYCLES - 16'd1;
  localparam logic [15:0] ERASE_LAST = 16'(ROM_DEPTH - 1);

  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
  logic        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [8:0]  addr_q, addr_d;
  logic [11:0] latch_q, latch_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] rd_sr_q, rd_sr_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;
  logic        dat_out_q, dat_out_d;
  logic        hold_q, hold_d;

  logic        clk_rise, clk_fall;
  logic [15:0] sr_in;

  // clk_s3_q is the previous synchronized level, used only for edge detect.
  assign clk_rise = clk_s2_q & ~clk_s3_q;
  assign clk_fall = ~clk_s2_q & clk_s3_q;
  // Bits arrive LSB first: after 6 shifts the command sits in [15:10],
  // after 16 shifts the whole frame sits in [15:0].
  assign sr_in    = {dat_s2_q, sr_q[15:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_s3_q   <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      addr_q     <= 9'h1FF;
      latch_q    <= 12'hFFF;
      bit_cnt_q  <= 5'd0;
      sr_q       <= 16'h0000;
      rd_sr_q    <= 16'h0000;
      busy_cnt_q <= 16'h0000;
      dat_out_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_s3_q   <= clk_s3_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      addr_q     <= addr_d;
      latch_q    <= latch_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      rd_sr_q    <= rd_sr_d;
      busy_cnt_q <= busy_cnt_d;
      dat_out_q  <= dat_out_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_s1_d   = icsp_clk;
    clk_s2_d   = clk_s1_q;
    clk_s3_d   = clk_s2_q;
    dat_s1_d   = icsp_dat_in;
    dat_s2_d   = dat_s1_q;
    addr_d     = addr_q;
    latch_d    = latch_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    rd_sr_d    = rd_sr_q;
    busy_cnt_d = busy_cnt_q;
    dat_out_d  = dat_out_q;
    hold_d     = prog_mode;

    case (state_q)
      IDLE: begin
        bit_cnt_d = 5'd0;
        if (prog_mode) state_d = CMD;
      end
      CMD: begin
        if (clk_fall) begin
          sr_d      = sr_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd5) begin
            bit_cnt_d = 5'd0;
            case (sr_in[15:10])
              6'h02: state_d = LOAD;
              6'h04: state_d = RD_FETCH;
              6'h06: addr_d  = addr_q + 9'd1;  // wraps 0x1FF -> 0x000
              6'h08: begin
                state_d    = PROG;
                busy_cnt_d = 16'd0;
              end
              6'h09: begin
                state_d    = ERASE;
                busy_cnt_d = 16'd0;
              end
              default: ;                       // End Programming and unknown codes
            endcase
          end
        end
      end
      LOAD: begin
        if (clk_fall) begin
          sr_d      = sr_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            latch_d   = sr_in[12:1];
            bit_cnt_d = 5'd0;
            state_d   = CMD;
          end
        end
      end
      RD_FETCH: begin
        // rom_adrs has carried the address since before the Read command
        // was clocked in, so rom_rdata already holds that word here.
        rd_sr_d   = {3'b000, rom_rdata, 1'b0};
        dat_out_d = 1'b0;
        state_d   = RD_SHIFT;
      end
      RD_SHIFT: begin
        if (clk_rise) begin
          dat_out_d = rd_sr_q[0];
          rd_sr_d   = {1'b0, rd_sr_q[15:1]};
        end
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            bit_cnt_d = 5'd0;
            dat_out_d = 1'b0;
            state_d   = CMD;
          end
        end
      end
      PROG: begin
        // Serial edges are ignored while busy; the bit counter stays at 0.
        bit_cnt_d  = 5'd0;
        busy_cnt_d = busy_cnt_q + 16'd1;
        if (busy_cnt_q == PROG_LAST) begin
          busy_cnt_d = 16'd0;
          state_d    = CMD;
        end
      end
      ERASE: begin
        // busy_cnt_q doubles as the erase address.
        bit_cnt_d  = 5'd0;
        busy_cnt_d = busy_cnt_q + 16'd1;
        if (busy_cnt_q == ERASE_LAST) begin
          busy_cnt_d = 16'd0;
          state_d    = CMD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving programming mode aborts whatever is in flight.
    if (!prog_mode) begin
      state_d    = IDLE;
      addr_d     = 9'h1FF;
      latch_d    = 12'hFFF;
      bit_cnt_d  = 5'd0;
      sr_d       = 16'h0000;
      rd_sr_d    = 16'h0000;
      busy_cnt_d = 16'd0;
      dat_out_d  = 1'b0;
    end
  end

  assign rom_adrs     = (state_q == ERASE) ? busy_cnt_q[8:0] : addr_q;
  assign rom_wdata    = (state_q == ERASE) ? 12'hFFF : latch_q;
  assign rom_we       = ((state_q == PROG) && (busy_cnt_q == 16'd0)) || (state_q == ERASE);
  assign busy         = (state_q == PROG) || (state_q == ERASE);
  assign icsp_dat_oe  = (state_q == RD_SHIFT);
  assign icsp_dat_out = dat_out_q;
  assign cpu_hold     = hold_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_icsp_loader.sv
// Testbench for icsp_loader: directed host command sequences, a ROM model,
// and a write scoreboard fed by the stimulus and drained by a monitor.
module tb_icsp_loader;

  localparam int HALF = 5;  // clk cycles per icsp_clk half period

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;

  logic        clk;
  logic        rst;
  logic        prog_mode;
  logic        icsp_clk;
  logic        icsp_dat_in;
  logic        icsp_dat_out;
  logic        icsp_dat_oe;
  logic [8:0]  rom_adrs;
  logic [11:0] rom_wdata;
  logic        rom_we;
  logic [11:0] rom_rdata;
  logic        busy;
  logic        cpu_hold;
  logic [2:0]  dbg_state;

  int checks;
  int errors;
  int busy_cycles;
  int we_count;

  logic [20:0] exp_q[$];

  logic [11:0] rom_mem [0:511];
  logic        fill_en;
  logic [11:0] fill_val;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  icsp_loader dut (
    .clk          (clk),
    .rst          (rst),
    .prog_mode    (prog_mode),
    .icsp_clk     (icsp_clk),
    .icsp_dat_in  (icsp_dat_in),
    .icsp_dat_out (icsp_dat_out),
    .icsp_dat_oe  (icsp_dat_oe),
    .rom_adrs     (rom_adrs),
    .rom_wdata    (rom_wdata),
    .rom_we       (rom_we),
    .rom_rdata    (rom_rdata),
    .busy         (busy),
    .cpu_hold     (cpu_hold),
    .dbg_state    (dbg_state)
  );

  // ROM model: synchronous write, registered read (one clk latency).
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 512; i++) rom_mem[i] <= fill_val;
    end else if (rom_we === 1'b1) begin
      rom_mem[rom_adrs] <= rom_wdata;
    end
    rom_rdata <= rom_mem[rom_adrs];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [20:0] e;
    if (busy === 1'b1) busy_cycles++;
    if (rom_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: adrs 0x%0h data 0x%0h, no write expected", rom_adrs, rom_wdata);
      end else begin
        e = exp_q.pop_front();
        check("rom_write", {11'd0, rom_adrs, rom_wdata}, {11'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    icsp_dat_in = b;
    icsp_clk    = 1'b1;
    tick(HALF);
    icsp_clk    = 1'b0;
    tick(HALF);
  endtask

  task automatic send_cmd(input logic [5:0] c);
    for (int i = 0; i < 6; i++) send_bit(c[i]);
  endtask

  task automatic send_data(input logic [11:0] w);
    logic [15:0] f;
    f = {3'b000, w, 1'b0};
    for (int i = 0; i < 16; i++) send_bit(f[i]);
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still high after %0d clk, expected low", n);
    end
  endtask

  task automatic read_word(output logic [15:0] w, output logic oe_ok);
    w     = 16'h0000;
    oe_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      icsp_clk = 1'b1;
      tick(HALF);
      w[i] = icsp_dat_out;
      if (icsp_dat_oe !== 1'b1) oe_ok = 1'b0;
      icsp_clk = 1'b0;
      tick(HALF);
      if (i < 15 && icsp_dat_oe !== 1'b1) oe_ok = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          b0;
    int          w0;
    int          bad;
    logic [15:0] rd;
    logic        oe_ok;
    logic [15:0] f;
    logic        found;

    checks      = 0;
    errors      = 0;
    busy_cycles = 0;
    we_count    = 0;
    rst         = 1'b1;
    prog_mode   = 1'b0;
    icsp_clk    = 1'b0;
    icsp_dat_in = 1'b0;
    fill_val    = 12'h000;
    fill_en     = 1'b1;
    tick(1);
    fill_en     = 1'b0;
    tick(3);

    // Reset state
    check("rst_rom_adrs", rom_adrs, 9'h1FF);
    check("rst_rom_wdata", rom_wdata, 12'hFFF);
    check("rst_rom_we", rom_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_dat_oe", icsp_dat_oe, 1'b0);
    check("rst_dat_out", icsp_dat_out, 1'b0);
    check("rst_state", dbg_state, S_IDLE);

    // rst wins over prog_mode
    prog_mode = 1'b1;
    tick(2);
    check("rst_over_prog_state", dbg_state, S_IDLE);
    check("rst_over_prog_hold", cpu_hold, 1'b0);
    rst = 1'b0;
    tick(3);
    check("cpu_hold_follows", cpu_hold, 1'b1);
    check("enter_cmd", dbg_state, S_CMD);

    // Increment, Load 0xA5C, Begin Programming
    send_cmd(6'h06);
    check("inc_wrap_to_000", rom_adrs, 9'h000);
    send_cmd(6'h02);
    send_data(12'hA5C);
    check("latch_a5c", rom_wdata, 12'hA5C);
    b0 = busy_cycles;
    w0 = we_count;
    exp_q.push_back({9'h000, 12'hA5C});
    send_cmd(6'h08);
    wait_not_busy();
    tick(2);
    check("prog_busy_len", busy_cycles - b0, 1000);
    check("prog_we_count", we_count - w0, 1);

    // Program 0x3C3 at 0x000, then Read Data
    send_cmd(6'h02);
    send_data(12'h3C3);
    exp_q.push_back({9'h000, 12'h3C3});
    send_cmd(6'h08);
    wait_not_busy();
    tick(2);
    check("rom0_programmed", rom_mem[0], 12'h3C3);
    send_cmd(6'h04);
    check("rd_oe_at_entry", icsp_dat_oe, 1'b1);
    read_word(rd, oe_ok);
    check("rd_bits", rd, 16'h0786);
    check("rd_oe_window", oe_ok, 1'b1);
    check("rd_oe_after", icsp_dat_oe, 1'b0);
    check("rd_state_cmd", dbg_state, S_CMD);

    // Unknown command then Load Data 0x123
    send_cmd(6'h3F);
    send_cmd(6'h02);
    send_data(12'h123);
    check("unknown_then_latch", rom_wdata, 12'h123);
    check("unknown_no_addr_change", rom_adrs, 9'h000);
    send_cmd(6'h06);
    check("framing_aligned_inc", rom_adrs, 9'h001);

    // 513 increments from reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("rst_again_adrs", rom_adrs, 9'h1FF);
    for (int i = 1; i <= 513; i++) begin
      send_cmd(6'h06);
      if (i == 1)   check("inc_1", rom_adrs, 9'h000);
      if (i == 256) check("inc_256", rom_adrs, 9'h0FF);
      if (i == 512) check("inc_512", rom_adrs, 9'h1FF);
      if (i == 513) check("inc_513_wrap", rom_adrs, 9'h000);
    end

    // Bulk Erase; commands clocked during erase must do nothing
    for (int i = 0; i < 512; i++) exp_q.push_back({9'(i), 12'hFFF});
    b0 = busy_cycles;
    w0 = we_count;
    send_cmd(6'h09);
    send_cmd(6'h06);
    send_cmd(6'h08);
    wait_not_busy();
    tick(2);
    check("erase_we_count", we_count - w0, 512);
    check("erase_busy_len", busy_cycles - b0, 512);
    check("erase_addr_kept", rom_adrs, 9'h000);
    check("erase_sb_drained", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (rom_mem[i] !== 12'hFFF) bad++;
    check("erase_all_fff", bad, 0);

    // Abort during Load Data at the 10th bit
    send_cmd(6'h06);
    send_cmd(6'h02);
    send_data(12'h321);
    check("pre_abort_latch", rom_wdata, 12'h321);
    check("pre_abort_adrs", rom_adrs, 9'h001);
    send_cmd(6'h02);
    f = {3'b000, 12'h456, 1'b0};
    for (int i = 0; i < 9; i++) send_bit(f[i]);
    icsp_dat_in = f[9];
    icsp_clk    = 1'b1;
    tick(2);
    w0 = we_count;
    prog_mode = 1'b0;
    tick(1);
    check("abort_load_state", dbg_state, S_IDLE);
    check("abort_load_adrs", rom_adrs, 9'h1FF);
    check("abort_load_latch", rom_wdata, 12'hFFF);
    check("abort_load_busy", busy, 1'b0);
    check("abort_load_hold", cpu_hold, 1'b0);
    icsp_clk = 1'b0;
    tick(HALF);
    check("abort_load_no_we", we_count - w0, 0);
    prog_mode = 1'b1;
    tick(3);
    check("reenter_cmd", dbg_state, S_CMD);

    // Abort during Bulk Erase at address 0x080
    fill_val = 12'h0AA;
    fill_en  = 1'b1;
    tick(1);
    fill_en  = 1'b0;
    tick(1);
    for (int i = 0; i <= 9'h080; i++) exp_q.push_back({9'(i), 12'hFFF});
    send_cmd(6'h09);
    found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      if (rom_we === 1'b1 && rom_adrs === 9'h080) found = 1'b1;
      else tick(1);
    end
    check("erase_reach_080", found, 1'b1);
    prog_mode = 1'b0;
    tick(1);
    check("abort_erase_state", dbg_state, S_IDLE);
    check("abort_erase_we", rom_we, 1'b0);
    check("abort_erase_busy", busy, 1'b0);
    check("abort_erase_adrs", rom_adrs, 9'h1FF);
    check("abort_erase_oe", icsp_dat_oe, 1'b0);
    tick(2);
    bad = 0;
    for (int i = 9'h081; i < 512; i++) if (rom_mem[i] !== 12'h0AA) bad++;
    check("rom_081_1ff_untouched", bad, 0);
    check("rom_07f_erased", rom_mem[9'h07F], 12'hFFF);
    check("final_sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icsp_loader.md
ICSP_LOADER -- requirements
Module: icsp_loader

Interface
REQ-001 Parameter PROG_CYCLES, default 16'd1000, clk cycles busy after each Begin Programming write.
REQ-002 Parameter ROM_DEPTH, default 512, number of program words; address width 9 bits.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 prog_mode  input  1  programming-mode entry (MCLR at VPP); low forces idle.
REQ-006 icsp_clk  input  1  host serial clock, asynchronous, synchronized internally.
REQ-007 icsp_dat_in  input  1  host serial data, asynchronous, synchronized internally.
REQ-008 icsp_dat_out  output  1  serial data driven to host during Read Data.
REQ-009 icsp_dat_oe  output  1  high while icsp_dat_out is driven.
REQ-010 rom_adrs  output  9  program memory address.
REQ-011 rom_wdata  output  12  program memory write word.
REQ-012 rom_we  output  1  single-cycle write strobe.
REQ-013 rom_rdata  input  12  program memory read word, valid one clk after rom_adrs.
REQ-014 busy  output  1  high during programming or bulk erase.
REQ-015 cpu_hold  output  1  holds core in reset while programming.

Function
REQ-016 icsp_clk and icsp_dat_in SHALL pass through 2-flop synchronizers; edges are detected on the synchronized icsp_clk (latency 3 clk from pin to edge pulse).
REQ-017 Inbound bits SHALL be sampled on synchronized icsp_clk falling edge, LSB first.
REQ-018 Command = 6 bits; decoded codes: 0x02 Load Data, 0x04 Read Data, 0x06 Increment Address, 0x08 Begin Programming, 0x0E End Programming, 0x09 Bulk Erase; any other code SHALL be discarded with no state change.
REQ-019 Data frame = 16 bits LSB first: bit0 start (0), bits12:1 word, bits15:13 zero; only bits12:1 are used, other bits ignored.
REQ-020 States: IDLE, CMD, LOAD, RD_FETCH, RD_SHIFT, PROG, ERASE.
REQ-021 IDLE -> CMD on prog_mode high; CMD collects 6 bits then dispatches.
REQ-022 Load Data: CMD -> LOAD; after 16 bits, data latch <= bits12:1; -> CMD.
REQ-023 Read Data: CMD -> RD_FETCH (1 clk, rom_adrs = address) -> RD_SHIFT capturing {3'b000, rom_rdata, 1'b0}; on each of next 16 synchronized icsp_clk rising edges the next bit (LSB first) SHALL appear on icsp_dat_out; icsp_dat_oe high from RD_SHIFT entry until the 16th falling edge; -> CMD.
REQ-024 Increment Address: address <= address + 1, wrapping 0x1FF -> 0x000; takes effect 1 clk after 6th command bit.
REQ-025 Begin Programming: -> PROG; rom_we high exactly one clk with rom_adrs = address, rom_wdata = data latch; busy high from that clk for PROG_CYCLES clk; -> CMD.
REQ-026 End Programming: accepted, no effect (writes already self-timed).
REQ-027 Bulk Erase: -> ERASE; rom_we high for ROM_DEPTH consecutive clk, rom_adrs 0x000..0x1FF ascending, rom_wdata = 0xFFF; busy high throughout; address counter unchanged; -> CMD.
REQ-028 icsp_clk edges while busy SHALL be ignored; bit counter held at 0.
REQ-029 rom_adrs SHALL equal address counter outside ERASE; rom_we low in all states except PROG first cycle and ERASE.
REQ-030 cpu_hold SHALL equal registered prog_mode (1 clk latency).
REQ-031 prog_mode falling mid-operation SHALL abort on next clk: state IDLE, rom_we low, busy low, oe low, address 0x1FF, latch 0xFFF; an ERASE in progress stops at the current address.

Reset
REQ-032 On rst: state IDLE, address 0x1FF, data latch 0xFFF, bit counter 0, busy counter 0, synchronizers 0.
REQ-033 On rst all outputs SHALL be 0 except rom_adrs = 0x1FF, rom_wdata = 0xFFF.
REQ-034 rst SHALL take priority over prog_mode and any in-flight command.

Verification
REQ-035 prog_mode=1, Increment Address, Load Data 0xA5C, Begin Programming -> one rom_we at rom_adrs 0x000, rom_wdata 0xA5C; busy high exactly 1000 clk.
REQ-036 ROM model holds 0x3C3 at 0x000; address 0x000, Read Data -> icsp_dat_out sequence LSB first = 0x0786 over 16 rising edges, oe high only for that window.
REQ-037 513 Increment Address commands from reset -> address 0x1FF->0x000->...->0x1FF then 0x000 (wrap checked).
REQ-038 Bulk Erase -> 512 consecutive rom_we, addresses 0x000..0x1FF, data 0xFFF; commands clocked during erase produce no effect.
REQ-039 prog_mode dropped at 10th bit of Load Data and again at erase address 0x080 -> IDLE next clk, no rom_we, address 0x1FF, ROM 0x081..0x1FF untouched.
REQ-040 Unknown command 0x3F then Load Data 0x123 -> 0x3F ignored, latch 0x123, framing stays aligned.
